// File: rtl/kgp_alu_pkg.sv
// Shared definitions for the KGP_RISC execute-stage shift unit:
// shift-op encodings, FSM state type and default widths.
package kgp_alu_pkg;

    localparam int WIDTH_DEF = 32;
    localparam int SHW_DEF   = 5;

    localparam logic [1:0] SH_SLL = 2'b00;
    localparam logic [1:0] SH_SRL = 2'b01;
    localparam logic [1:0] SH_SRA = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } sh_state_e;

endpackage

// File: rtl/kgp_seq_shifter_if.sv
// Request/response bundle between the execute stage and the serial shifter.
interface kgp_seq_shifter_if
    import kgp_alu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int SHW   = SHW_DEF
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] operand;
    logic [SHW-1:0]   shamt;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             carry_out;
    logic             carry_we;

    modport master (
        output start, op, operand, shamt,
        input  busy, done, result, carry_out, carry_we
    );

    modport slave (
        input  start, op, operand, shamt,
        output busy, done, result, carry_out, carry_we
    );
endinterface

// File: rtl/kgp_seq_shifter.sv
// Serial shift unit: one bit per cycle for shll/shrl/shra, reporting the
// final shifted value and the last bit shifted out to the carry-flag flop.
module kgp_seq_shifter
    import kgp_alu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int SHW   = SHW_DEF
) (
    input  logic               clk,
    input  logic               rst,
    kgp_seq_shifter_if.slave   sh
);

    // Returns {bit shifted out, shifted value}; reserved op 2'b11 shifts left.
    function automatic logic [WIDTH:0] shift_step(input logic [1:0] op,
                                                  input logic [WIDTH-1:0] v);
        case (op)
            SH_SRL:  return {v[0], 1'b0, v[WIDTH-1:1]};
            SH_SRA:  return {v[0], v[WIDTH-1], v[WIDTH-1:1]};
            default: return {v[WIDTH-1], v[WIDTH-2:0], 1'b0};
        endcase
    endfunction

    sh_state_e        state_q,     state_d;
    logic [WIDTH-1:0] sreg_q,      sreg_d;
    logic [1:0]       op_q,        op_d;
    logic [SHW-1:0]   count_q,     count_d;
    logic             nz_q,        nz_d;
    logic             busy_q,      busy_d;
    logic             done_q,      done_d;
    logic             carry_we_q,  carry_we_d;
    logic             carry_out_q, carry_out_d;
    logic [WIDTH-1:0] result_q,    result_d;
    logic [WIDTH:0]   step;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            sreg_q      <= '0;
            op_q        <= SH_SLL;
            count_q     <= '0;
            nz_q        <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            carry_we_q  <= 1'b0;
            carry_out_q <= 1'b0;
            result_q    <= '0;
        end else begin
            state_q     <= state_d;
            sreg_q      <= sreg_d;
            op_q        <= op_d;
            count_q     <= count_d;
            nz_q        <= nz_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            carry_we_q  <= carry_we_d;
            carry_out_q <= carry_out_d;
            result_q    <= result_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        sreg_d      = sreg_q;
        op_d        = op_q;
        count_d     = count_q;
        nz_d        = nz_q;
        carry_out_d = carry_out_q;
        result_d    = result_q;
        step        = shift_step(op_q, sreg_q);

        case (state_q)
            ST_IDLE: begin
                if (sh.start) begin
                    sreg_d  = sh.operand;
                    op_d    = sh.op;
                    count_d = sh.shamt;
                    nz_d    = (sh.shamt != '0);
                    state_d = (sh.shamt != '0) ? ST_SHIFT : ST_DONE;
                end
            end
            ST_SHIFT: begin
                carry_out_d = step[WIDTH];
                sreg_d      = step[WIDTH-1:0];
                count_d     = count_q - 1'b1;
                if (count_q == SHW'(1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are registered from the next state so they line up with it.
        if (state_d == ST_DONE) begin
            result_d = sreg_d;
        end
        busy_d     = (state_d != ST_IDLE);
        done_d     = (state_d == ST_DONE);
        carry_we_d = (state_d == ST_DONE) && nz_d;
    end

    assign sh.busy      = busy_q;
    assign sh.done      = done_q;
    assign sh.carry_we  = carry_we_q;
    assign sh.carry_out = carry_out_q;
    assign sh.result    = result_q;

endmodule

// File: tb/tb_kgp_seq_shifter.sv
// Self-checking bench for kgp_seq_shifter: directed cases plus random traffic
// checked every cycle against an arithmetic reference of the shift unit.
module tb_kgp_seq_shifter;
    import kgp_alu_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    kgp_seq_shifter_if #(.WIDTH(32), .SHW(5)) bus ();

    kgp_seq_shifter #(.WIDTH(32), .SHW(5)) dut (
        .clk (clk),
        .rst (rst),
        .sh  (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_en   = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic logic [31:0] ref_res(input logic [1:0] op, input logic [31:0] x, input int s);
        case (op)
            SH_SRL:  return x >> s;
            SH_SRA:  return 32'($signed(x) >>> s);
            default: return x << s;
        endcase
    endfunction

    function automatic logic ref_carry(input logic [1:0] op, input logic [31:0] x, input int s);
        if (s == 0) return 1'b0;
        if (op == SH_SRL || op == SH_SRA) return x[s-1];
        return x[32-s];
    endfunction

    // Reference: an accepted request keeps the unit busy for shamt+1 cycles,
    // the last of which is the done cycle.
    int          m_left;
    logic [31:0] m_result, m_pend_res;
    logic        m_carry, m_pend_c, m_nz;

    always @(posedge clk or posedge rst) begin : model
        int          left;
        logic [31:0] pres;
        logic        pc, nz;
        if (rst) begin
            m_left   <= 0;
            m_result <= '0;
            m_carry  <= 1'b0;
            m_nz     <= 1'b0;
        end else begin
            left = m_left;
            pres = m_pend_res;
            pc   = m_pend_c;
            nz   = m_nz;
            if (left > 0) begin
                left = left - 1;
            end else if (bus.start) begin
                left = int'(bus.shamt) + 1;
                nz   = (bus.shamt != 0);
                pres = ref_res(bus.op, bus.operand, int'(bus.shamt));
                pc   = ref_carry(bus.op, bus.operand, int'(bus.shamt));
            end
            m_left     <= left;
            m_nz       <= nz;
            m_pend_res <= pres;
            m_pend_c   <= pc;
            if (left == 1) begin
                m_result <= pres;
                if (nz) m_carry <= pc;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            if (rst) begin
                chk("rst_busy", bus.busy, 0);
                chk("rst_done", bus.done, 0);
                chk("rst_carry_we", bus.carry_we, 0);
                chk("rst_result", bus.result, 0);
                chk("rst_carry_out", bus.carry_out, 0);
            end else begin
                chk("busy", bus.busy, (m_left > 0));
                chk("done", bus.done, (m_left == 1));
                chk("carry_we", bus.carry_we, (m_left == 1) && m_nz);
                if (m_left <= 1) chk("result", bus.result, m_result);
                if (m_left == 0 || (m_left == 1 && m_nz)) chk("carry_out", bus.carry_out, m_carry);
            end
        end
    end

    // Issues one request, optionally injects a second start at loop cycle inj,
    // then observes a 40-cycle window against literal expectations.
    task automatic do_op(input string name, input logic [1:0] op, input logic [31:0] x,
                         input logic [4:0] s, input logic [31:0] lit_res, input logic lit_c,
                         input logic lit_we, input int lit_busy, input int inj);
        int busy_cyc = 0;
        int dones    = 0;
        @(posedge clk); #2;
        bus.start = 1'b1; bus.op = op; bus.operand = x; bus.shamt = s;
        @(posedge clk); #2;
        bus.start = 1'b0; bus.op = 2'($urandom_range(0, 3));
        bus.operand = $urandom; bus.shamt = 5'($urandom_range(0, 31));
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.busy) busy_cyc++;
            if (bus.done) begin
                dones++;
                if (dones == 1) begin
                    chk({name, "_res"}, bus.result, lit_res);
                    chk({name, "_model_res"}, m_result, lit_res);
                    chk({name, "_we"}, bus.carry_we, lit_we);
                    if (lit_we) chk({name, "_carry"}, bus.carry_out, lit_c);
                end
            end
            if (i == inj) begin
                bus.start = 1'b1; bus.op = SH_SLL; bus.shamt = 5'd1;
            end else begin
                bus.start = 1'b0;
            end
        end
        chk({name, "_done_count"}, dones, 1);
        chk({name, "_busy_cycles"}, busy_cyc, lit_busy);
    endtask

    initial begin
        int dones;
        bus.start = 1'b0; bus.op = SH_SLL; bus.operand = '0; bus.shamt = '0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        chk_en = 1'b1;
        @(posedge clk); #2;
        rst = 1'b0;
        repeat (10) @(posedge clk);

        do_op("sll1", SH_SLL, 32'h8000_0001, 5'd1, 32'h0000_0002, 1'b1, 1'b1, 2, -1);
        do_op("sra5", SH_SRA, 32'hF000_0010, 5'd5, 32'hFF80_0000, 1'b1, 1'b1, 6, -1);
        do_op("zero", SH_SRL, 32'h1234_5678, 5'd0, 32'h1234_5678, 1'b0, 1'b0, 1, -1);
        do_op("busy_start", SH_SRL, 32'hFFFF_FFFF, 5'd31, 32'h0000_0001, 1'b1, 1'b1, 32, 1);
        do_op("sra31", SH_SRA, 32'hA000_0000, 5'd31, 32'hFFFF_FFFF, 1'b0, 1'b1, 32, -1);
        do_op("rsvd", 2'b11, 32'h0000_00F0, 5'd4, 32'h0000_0F00, 1'b0, 1'b1, 5, -1);

        // Abort a long shift with an asynchronous reset between edges.
        @(posedge clk); #2;
        bus.start = 1'b1; bus.op = SH_SLL; bus.operand = 32'hDEAD_BEEF; bus.shamt = 5'd20;
        @(posedge clk); #2;
        bus.start = 1'b0;
        repeat (6) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("abort_busy", bus.busy, 0);
        chk("abort_done", bus.done, 0);
        chk("abort_we", bus.carry_we, 0);
        chk("abort_result", bus.result, 0);
        @(posedge clk); #2;
        rst = 1'b0;
        dones = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (bus.done || bus.carry_we) dones++;
        end
        chk("abort_no_resp", dones, 0);
        do_op("after_abort", SH_SLL, 32'h1000_0003, 5'd4, 32'h0000_0030, 1'b1, 1'b1, 5, -1);

        // Random traffic, including starts while busy and changing inputs.
        for (int c = 0; c < 600; c++) begin
            @(posedge clk); #2;
            bus.start   = ($urandom_range(0, 2) == 0);
            bus.op      = 2'($urandom_range(0, 3));
            bus.operand = $urandom;
            case ($urandom_range(0, 3))
                0:       bus.shamt = 5'($urandom_range(0, 3));
                1:       bus.shamt = 5'd31;
                default: bus.shamt = 5'($urandom_range(0, 31));
            endcase
        end
        @(posedge clk); #2;
        bus.start = 1'b0;
        repeat (40) @(posedge clk);
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/kgp_seq_shifter.md
Name: kgp_seq_shifter

Overview:
- Multi-cycle serial shift unit for the KGP_RISC execute stage.
- Handles the shll/shrl/shra instruction family and their variable-amount forms.
- Shifts one bit per cycle and produces the 32-bit result plus the last bit shifted out.
- Its carry_out/carry_we pair drives the single-bit carry-flag flip-flop that sits directly downstream. The flag flop loads carry_out when carry_we is high.

Parameters:
- WIDTH, 32, operand/result width.
- SHW, 5, shift-amount width (log2 WIDTH).

Ports:
- clk  in  1  system clock; all state changes on posedge clk.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- op  in  2  shift type: SLL=2'b00, SRL=2'b01, SRA=2'b10; 2'b11 reserved, treated as SLL.
- operand  in  WIDTH  value to shift; captured with start.
- shamt  in  SHW  shift amount 0..31; captured with start.
- busy  out  1  high in SHIFT and DONE.
- done  out  1  one-cycle pulse; result valid.
- result  out  WIDTH  shifted value; holds until next accepted start.
- carry_out  out  1  last bit shifted out.
- carry_we  out  1  one-cycle write strobe to the carry-flag flop; coincides with done.

Behaviour:
- Reset (async, rst=1): state=IDLE, busy=0, done=0, carry_we=0, carry_out=0, result=0, internal count=0. Reset asserted mid-operation aborts immediately. No done or carry_we is produced for the aborted request.
- All outputs are registered; no combinational input-to-output path.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - If start=1 at a posedge, capture operand into the shift register, capture op, and load count=shamt.
  - If shamt!=0, go to SHIFT. If shamt==0, go to DONE.
  - start=0 keeps state IDLE.
- SHIFT: each posedge performs one single-bit shift and decrements count.
  - SLL: carry_out<=reg[WIDTH-1], reg<={reg[WIDTH-2:0],0}.
  - SRL: carry_out<=reg[0], reg<={0,reg[WIDTH-1:1]}.
  - SRA: carry_out<=reg[0], reg<={reg[WIDTH-1],reg[WIDTH-1:1]}.
  - When count==1 at the edge, that edge performs the final shift and the state moves to DONE.
- DONE: lasts exactly one cycle.
  - done=1; result=reg.
  - carry_we=1 if captured shamt!=0, else carry_we=0; the flag is unchanged for a zero shift.
  - Next edge returns to IDLE.
- Latency: start accepted at edge E. done is high during the cycle after edge E+shamt for shamt>=1, and after edge E for shamt=0.
- start while busy is ignored. It is not queued and does not disturb the operation in flight. start in the DONE cycle is also ignored; it is accepted only one cycle later, in IDLE.
- operand/op/shamt changes after capture have no effect.
- carry_out is meaningful only while carry_we=1. Between operations it holds its last value.
- shamt=31 with SRA of a negative value: result=32'hFFFFFFFF, carry_out=bit 30 of the operand.

Decomposition:
- Shared package kgp_alu_pkg holds:
  - op encodings SH_SLL/SH_SRL/SH_SRA;
  - state encoding typedef (IDLE/SHIFT/DONE);
  - WIDTH/SHW defaults.
- No sub-module. The one-bit shift step is a local function inside the block.
- The downstream carry-flag flop is instantiated by the parent, not inside this block.

Test Plan:
- Reset then idle: rst pulse, no start for 10 cycles -> busy=0, done=0, carry_we=0, result=0 throughout.
- SLL: operand=32'h8000_0001, shamt=1, op=SLL -> done 1 cycle after start edge + 1 shift; result=32'h0000_0002, carry_out=1, carry_we=1 for exactly one cycle.
- SRA: operand=32'hF000_0010, shamt=5, op=SRA -> done after 5 shift cycles; result=32'hFF80_0000, carry_out=1 (bit 4), busy high for 6 cycles.
- Zero shift: operand=32'h1234_5678, shamt=0, op=SRL -> done one cycle after start; result=32'h1234_5678, carry_we=0.
- Start while busy: SRL operand=32'hFFFF_FFFF, shamt=31; second start with shamt=1 in cycle 3 -> single done after 31 shifts; result=32'h0000_0001, carry_out=1; the second request produces no response.
- Async reset mid-shift: SLL shamt=20, assert rst at shift 7 between edges -> outputs clear immediately; no done/carry_we afterward. A fresh start after release behaves normally.
